spi_reg_rx: RTL



---
 rtl/spi_reg_rx.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_reg_rx.sv
// spi_reg_rx: write-only SPI slave (mode 0). It synchronizes the SPI pins into
// clk, deserializes MSB-first {addr, data} frames and emits one-cycle register
// write strobes. It flags frames that are aborted by an early deselect.
module spi_reg_rx #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_nss,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
    logic [FRAME_W-1:0] shift, shift_nx;
    logic               wr_en_nx, err_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic [DATA_W-1:0]  data_nx;

    logic nss_q1, nss_s;
    logic sck_q1, sck_s, sck_d;
    logic mosi_q1, mosi_s;
    logic sck_rise;

    // Equal-depth 2-FF synchronizers keep MOSI aligned with SCK; sck_d feeds edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            nss_q1  <= 1'b1;
            nss_s   <= 1'b1;
            sck_q1  <= 1'b0;
            sck_s   <= 1'b0;
            sck_d   <= 1'b0;
            mosi_q1 <= 1'b0;
            mosi_s  <= 1'b0;
        end else begin
            nss_q1  <= spi_nss;
            nss_s   <= nss_q1;
            sck_q1  <= spi_clk;
            sck_s   <= sck_q1;
            sck_d   <= sck_s;
            mosi_q1 <= spi_mosi;
            mosi_s  <= mosi_q1;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign busy     = (state == ACTIVE);

    // Next state: deselect takes priority over a coincident SCK rise
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_nx = shift;
        wr_en_nx = 1'b0;
        err_nx   = 1'b0;
        addr_nx  = wr_addr;
        data_nx  = wr_data;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!nss_s) state_nx = ACTIVE;
            end
            ACTIVE: begin
                if (nss_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    err_nx   = (cnt != '0);
                end else if (sck_rise) begin
                    shift_nx = {shift[FRAME_W-2:0], mosi_s};
                    if (cnt_inc == CNT_W'(FRAME_W)) begin
                        cnt_nx   = '0;
                        wr_en_nx = 1'b1;
                        addr_nx  = shift_nx[FRAME_W-1:DATA_W];
                        data_nx  = shift_nx[DATA_W-1:0];
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; wr_addr/wr_data hold the last completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shift     <= shift_nx;
            wr_en     <= wr_en_nx;
            frame_err <= err_nx;
            wr_addr   <= addr_nx;
            wr_data   <= data_nx;
        end
    end
endmodule
